// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC accumulator.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    localparam int unsigned ACC_W_DEF   = 40;
    localparam int unsigned N_TERMS_DEF = 16;
    localparam int unsigned PROD_W      = 32;

endpackage

// File: rtl/sat_add.sv
// Accumulator adder with carry-out; clamps to all-ones on carry when MAC_ACCUM_SAT_EN is defined,
// otherwise wraps modulo 2^ACC_W.
module sat_add import mac_pkg::*; #(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full;

    always_comb begin
        full    = {1'b0, a_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, b_i};
        carry_o = full[ACC_W];
`ifdef MAC_ACCUM_SAT_EN
        sum_o   = carry_o ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        sum_o   = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accum.sv
// Accumulates N_TERMS unsigned 32-bit products, then holds the sum until the consumer takes it.
// Optional saturation on overflow via MAC_ACCUM_SAT_EN (see sat_add).
module mac_accum import mac_pkg::*; #(
    parameter  int unsigned N_TERMS = N_TERMS_DEF,
    parameter  int unsigned ACC_W   = ACC_W_DEF,
    localparam int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              ovf
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_TERMS);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic             ovf_q, ovf_d;
    logic             prod_ready_q, prod_ready_d;
    logic             acc_valid_q, acc_valid_d;
    logic [ACC_W-1:0] sum;
    logic             carry;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a_i     (acc_q),
        .b_i     (prod),
        .sum_o   (sum),
        .carry_o (carry)
    );

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d   = sum;
                    count_d = count_inc;
                    ovf_d   = ovf_q | carry;
                    if (count_inc == LastCnt) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Back-to-back restart skips IDLE entirely.
                if (acc_ready) begin
                    if (start) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        prod_ready_d = (state_d == ACCUM);
        acc_valid_d  = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            acc_valid_q  <= acc_valid_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign acc_valid  = acc_valid_q;
    assign acc        = acc_q;
    assign count      = count_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule
